// File: rtl/rx_eth_dispatch.sv
// ---------------------------------------------------------------------------
// rx_eth_dispatch
//
// Receive-side Ethernet frame sequencer placed between the MAC byte stream
// and the protocol parsers. It walks the L2 header, filters on destination
// address, steers payload bytes to the IPv4 or ARP parser, strips the FCS
// through a 4-byte delay line and pulses a per-frame parser clear.
//
// Ports
//   RX_CLK           in   receive clock, all logic on its rising edge
//   rst_n            in   asynchronous active-low reset
//   mac_addr         in   local station MAC address
//   rx_en            in   frame byte valid, high for the whole frame
//   rx_byte          in   frame byte, first byte = destination MAC MSB
//   rx_payload       out  forwarded payload byte
//   rx_payload_ipv4  out  rx_payload is an IPv4 payload byte
//   rx_payload_arp   out  rx_payload is an ARP payload byte
//   rx_parser_clr    out  one-cycle pulse, parser restart
//   rx_src_mac       out  source MAC of the current/last frame
//   rx_ethertype     out  EtherType of the current/last frame
//   rx_frame_end     out  one-cycle pulse, accepted frame completed
//   rx_frame_drop    out  one-cycle pulse, frame discarded
//   rx_frame_cnt     out  accepted frames, saturating
//   rx_drop_cnt      out  dropped frames, saturating
//   rx_dbg_state     out  current FSM state (debug observation)
//
// Handshake: rx_en/rx_byte is a valid-only stream with no backpressure; a
// byte is consumed on every rising edge where rx_en is high. The payload
// strobes are likewise valid-only: rx_payload is meaningful exactly in the
// cycles where one of rx_payload_ipv4 / rx_payload_arp is high.
// ---------------------------------------------------------------------------
module rx_eth_dispatch #(
   parameter int                 OCT         = 8,
   parameter logic [2*OCT-1:0]   ETH_IPV4    = 16'h0800,
   parameter logic [2*OCT-1:0]   ETH_ARP     = 16'h0806,
   parameter int                 MAX_PAYLOAD = 1500,
   parameter int                 CNT_W       = 16
) (
   input  logic                 RX_CLK,
   input  logic                 rst_n,
   input  logic [OCT*6-1:0]     mac_addr,
   input  logic                 rx_en,
   input  logic [OCT-1:0]       rx_byte,
   output logic [OCT-1:0]       rx_payload,
   output logic                 rx_payload_ipv4,
   output logic                 rx_payload_arp,
   output logic                 rx_parser_clr,
   output logic [OCT*6-1:0]     rx_src_mac,
   output logic [OCT*2-1:0]     rx_ethertype,
   output logic                 rx_frame_end,
   output logic                 rx_frame_drop,
   output logic [CNT_W-1:0]     rx_frame_cnt,
   output logic [CNT_W-1:0]     rx_drop_cnt,
   output logic [2:0]           rx_dbg_state
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_DST  = 3'd1;
   localparam logic [2:0] S_SRC  = 3'd2;
   localparam logic [2:0] S_TYPE = 3'd3;
   localparam logic [2:0] S_PAY  = 3'd4;
   localparam logic [2:0] S_DROP = 3'd5;

   // Forwarded-byte counter must be able to hold MAX_PAYLOAD.
   localparam int              PW      = $clog2(MAX_PAYLOAD + 1) + 1;
   localparam logic [PW-1:0]   MAX_FWD = PW'(MAX_PAYLOAD);
   localparam logic [OCT*6-1:0] BCAST  = {(OCT*6){1'b1}};

   logic [2:0]              r_state;
   logic [2:0]              r_hdr_cnt;   // bytes taken in the current header field
   logic [OCT*6-1:0]        r_dst;
   logic [3:0][OCT-1:0]     r_dly;       // FCS strip delay line, [3] is oldest
   logic [2:0]              r_fill;      // bytes held in the delay line (0..4)
   logic [PW-1:0]           r_fwd_cnt;   // payload bytes forwarded this frame
   logic                    r_is_arp;
   logic                    r_armed;     // rx_en has been seen low since reset

   logic [2:0]              w_next;
   logic                    w_drop_evt;
   logic                    w_end_evt;
   logic                    w_fwd;
   logic [OCT*6-1:0]        w_dst_full;
   logic [OCT*2-1:0]        w_type_full;

   assign w_dst_full   = {r_dst[OCT*5-1:0], rx_byte};
   assign w_type_full  = {rx_ethertype[OCT-1:0], rx_byte};
   assign rx_dbg_state = r_state;

   // Next state and frame events; all outputs are registered from these.
   always_comb begin
      w_next     = r_state;
      w_drop_evt = 1'b0;
      w_end_evt  = 1'b0;
      w_fwd      = 1'b0;
      case (r_state)
         S_IDLE: begin
            // After reset the stream may be mid-frame; only a byte that
            // follows an rx_en-low cycle can start a frame.
            if (rx_en && r_armed) w_next = S_DST;
         end
         S_DST: begin
            if (!rx_en) begin
               w_next     = S_IDLE;
               w_drop_evt = 1'b1;
            end else if (r_hdr_cnt == 3'd5) begin
               if (w_dst_full == mac_addr || w_dst_full == BCAST) begin
                  w_next = S_SRC;
               end else begin
                  w_next     = S_DROP;
                  w_drop_evt = 1'b1;
               end
            end
         end
         S_SRC: begin
            if (!rx_en) begin
               w_next     = S_IDLE;
               w_drop_evt = 1'b1;
            end else if (r_hdr_cnt == 3'd5) begin
               w_next = S_TYPE;
            end
         end
         S_TYPE: begin
            if (!rx_en) begin
               w_next     = S_IDLE;
               w_drop_evt = 1'b1;
            end else if (r_hdr_cnt == 3'd1) begin
               if (w_type_full == ETH_IPV4 || w_type_full == ETH_ARP) begin
                  w_next = S_PAY;
               end else begin
                  w_next     = S_DROP;
                  w_drop_evt = 1'b1;
               end
            end
         end
         S_PAY: begin
            if (!rx_en) begin
               // The four held bytes are the FCS and are simply abandoned.
               w_next = S_IDLE;
               if (r_fwd_cnt != '0) w_end_evt  = 1'b1;
               else                 w_drop_evt = 1'b1;
            end else if (r_fill == 3'd4) begin
               if (r_fwd_cnt == MAX_FWD) begin
                  // Oversize: the parser has seen a partial payload and is
                  // told to discard it through the drop pulse.
                  w_next     = S_DROP;
                  w_drop_evt = 1'b1;
               end else begin
                  w_fwd = 1'b1;
               end
            end
         end
         S_DROP: begin
            if (!rx_en) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge RX_CLK or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= S_IDLE;
         r_hdr_cnt       <= 3'd0;
         r_dst           <= '0;
         r_dly           <= '0;
         r_fill          <= 3'd0;
         r_fwd_cnt       <= '0;
         r_is_arp        <= 1'b0;
         r_armed         <= 1'b0;
         rx_payload      <= '0;
         rx_payload_ipv4 <= 1'b0;
         rx_payload_arp  <= 1'b0;
         rx_parser_clr   <= 1'b0;
         rx_src_mac      <= '0;
         rx_ethertype    <= '0;
         rx_frame_end    <= 1'b0;
         rx_frame_drop   <= 1'b0;
         rx_frame_cnt    <= '0;
         rx_drop_cnt     <= '0;
      end else begin
         r_state         <= w_next;
         rx_parser_clr   <= (r_state == S_IDLE) && (w_next == S_DST);
         rx_frame_end    <= w_end_evt;
         rx_frame_drop   <= w_drop_evt;
         rx_payload_ipv4 <= w_fwd && !r_is_arp;
         rx_payload_arp  <= w_fwd &&  r_is_arp;
         if (w_fwd) rx_payload <= r_dly[3];

         if (!rx_en) r_armed <= 1'b1;

         if (w_end_evt && rx_frame_cnt != {CNT_W{1'b1}})
            rx_frame_cnt <= rx_frame_cnt + CNT_W'(1);
         if (w_drop_evt && rx_drop_cnt != {CNT_W{1'b1}})
            rx_drop_cnt <= rx_drop_cnt + CNT_W'(1);

         case (r_state)
            S_IDLE: begin
               if (w_next == S_DST) begin
                  r_dst     <= w_dst_full;
                  r_hdr_cnt <= 3'd1;
                  r_fill    <= 3'd0;
                  r_fwd_cnt <= '0;
               end
            end
            S_DST: begin
               if (rx_en) begin
                  r_dst     <= w_dst_full;
                  r_hdr_cnt <= (w_next != r_state) ? 3'd0 : r_hdr_cnt + 3'd1;
               end
            end
            S_SRC: begin
               if (rx_en) begin
                  rx_src_mac <= {rx_src_mac[OCT*5-1:0], rx_byte};
                  r_hdr_cnt  <= (w_next != r_state) ? 3'd0 : r_hdr_cnt + 3'd1;
               end
            end
            S_TYPE: begin
               if (rx_en) begin
                  rx_ethertype <= w_type_full;
                  r_is_arp     <= (w_type_full == ETH_ARP);
                  r_hdr_cnt    <= (w_next != r_state) ? 3'd0 : r_hdr_cnt + 3'd1;
               end
            end
            S_PAY: begin
               if (rx_en && w_next == S_PAY) begin
                  r_dly <= {r_dly[2:0], rx_byte};
                  if (r_fill != 3'd4) r_fill    <= r_fill + 3'd1;
                  if (w_fwd)          r_fwd_cnt <= r_fwd_cnt + PW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/rx_eth_dispatch.md
Name: rx_eth_dispatch

Overview:
Receive-side Ethernet frame sequencer that sits between the MAC byte stream and the protocol parsers.
- Walks the L2 header (destination MAC, source MAC, EtherType) and filters on destination address.
- Steers payload bytes to the IPv4 or ARP parser by asserting exactly one of their qualifying strobes.
- Strips the 4-byte FCS through a delay line.
- Pulses a per-frame clear so the parsers restart at their first header state on every frame.

Parameters:
- OCT, 8, byte width.
- ETH_IPV4, 16'h0800, EtherType routed to rx_payload_ipv4.
- ETH_ARP, 16'h0806, EtherType routed to rx_payload_arp.
- MAX_PAYLOAD, 1500, maximum forwarded payload bytes (FCS excluded).
- CNT_W, 16, width of the frame and drop counters.

Ports:
- RX_CLK  in  1  receive clock, all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mac_addr  in  OCT*6  local station MAC address.
- rx_en  in  1  frame byte valid; high continuously for one frame (preamble/SFD already removed); low for at least 1 cycle between frames.
- rx_byte  in  OCT  frame byte, first byte = destination MAC MSB.
- rx_payload  out  OCT  forwarded payload byte.
- rx_payload_ipv4  out  1  rx_payload is an IPv4 payload byte.
- rx_payload_arp  out  1  rx_payload is an ARP payload byte.
- rx_parser_clr  out  1  one-cycle pulse, parser restart.
- rx_src_mac  out  OCT*6  source MAC of the current/last accepted frame.
- rx_ethertype  out  OCT*2  EtherType of the current/last frame.
- rx_frame_end  out  1  one-cycle pulse, accepted frame completed.
- rx_frame_drop  out  1  one-cycle pulse, frame discarded.
- rx_frame_cnt  out  CNT_W  accepted frames, saturating.
- rx_drop_cnt  out  CNT_W  dropped frames, saturating.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; delay line empty; byte counter 0.
- IDLE
  - rx_en high: capture byte as dst[47:40], pulse rx_parser_clr in the next cycle, go DST_MAC (count = 1).
- DST_MAC (6 bytes total)
  - Shift bytes in.
  - After byte 6: go SRC_MAC if dst == mac_addr or dst == 48'hFFFF_FFFF_FFFF; otherwise go DROP.
- SRC_MAC (6 bytes): shift into rx_src_mac, then go TYPE.
- TYPE (2 bytes)
  - Shift into rx_ethertype, MSB first.
  - Then go PAYLOAD if ETH_IPV4 or ETH_ARP; any other value goes DROP.
- PAYLOAD
  - Each byte enters a 4-entry delay line.
  - Once 4 bytes are held, each new byte pushes out the oldest.
  - The pushed-out byte appears on rx_payload one cycle after the push, with the strobe matching rx_ethertype asserted for that cycle.
  - The strobe is never asserted for FCS bytes.
  - Total latency: payload byte n is output the cycle after byte n+4 is sampled.
- Payload byte counter counts forwarded bytes.
  - If a push would make the count MAX_PAYLOAD+1: that byte is not forwarded, strobes go low, state DROP.
- End of frame in PAYLOAD (rx_en low): the 4 held bytes are discarded as FCS.
  - At least 1 payload byte forwarded: pulse rx_frame_end, increment rx_frame_cnt, go IDLE.
  - Otherwise (fewer than 5 post-type bytes): runt, so pulse rx_frame_drop, increment rx_drop_cnt, go IDLE.
- rx_en low in DST_MAC, SRC_MAC or TYPE: runt; pulse rx_frame_drop, increment rx_drop_cnt, go IDLE.
- DROP
  - Pulse rx_frame_drop and increment rx_drop_cnt once, on entry.
  - Strobes low; wait for rx_en low, then go IDLE.
  - Oversize payload: the downstream parser has already seen a partial payload; rx_frame_drop tells it to discard.
- Counters saturate at all-ones with no wrap.
- Strobe rules:
  - rx_payload_ipv4 and rx_payload_arp are never high together.
  - Both are low in every state except PAYLOAD output cycles.
- rx_en re-asserted in the same cycle the FSM returns to IDLE is illegal (the MAC guarantees a gap); behaviour is unspecified.
- Reset mid-frame: immediate return to IDLE, no pulses, counters cleared. The rest of that frame is treated as a new frame only if rx_en deasserts first. IDLE requires rx_en low for one cycle after reset release before accepting a frame.

Test Plan:
- Unicast IPv4, dst = mac_addr = 02:00:00:00:00:01, type 0800, 20 payload + 4 FCS bytes:
  - rx_parser_clr pulses once.
  - 20 cycles of rx_payload_ipv4 carrying exactly bytes 15..34.
  - First output 1 cycle after frame byte 19 is sampled.
  - No FCS byte forwarded.
  - rx_frame_end = 1, rx_frame_cnt = 1.
- Broadcast ARP, type 0806, 28 + 4 bytes: 28 rx_payload_arp cycles, ipv4 strobe never high, rx_src_mac captured correctly.
- Dst = 02:00:00:00:00:02 (mismatch): no strobes at all, one rx_frame_drop, rx_drop_cnt = 1, FSM back to IDLE after rx_en falls.
- EtherType 86DD: dropped, no strobes, rx_ethertype = 16'h86DD.
- Runt frame of 10 bytes (rx_en falls in SRC_MAC): rx_frame_drop pulses, no strobes, the next back-to-back valid frame is accepted normally.
- Oversize IPv4 frame, 1501 payload + 4 FCS bytes:
  - Exactly 1500 strobed bytes, then rx_frame_drop.
  - rx_frame_cnt unchanged.
- Asynchronous reset asserted mid-payload:
  - Outputs zero immediately, without a clock edge.
  - The following frame is parsed correctly.
- Counter saturation: preload via 65 536 drops with CNT_W = 16; the counter stays at 16'hFFFF.
